// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : single-outstanding 64x32 data-memory responder with a
// fixed request-to-response latency. Optional byte-lane write masking is
// selected with `define DMEM_BYTE_MASK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        inp_clk,
  input  logic        inp_rst_n,
  input  logic        inp_req_valid,
  output logic        out_req_ready,
  input  logic        inp_req_we,
  input  logic [31:0] inp_req_addr,
  input  logic [31:0] inp_req_wdata,
  input  logic [3:0]  inp_req_be,
  output logic        out_rsp_valid,
  output logic [31:0] out_rsp_rdata,
  output logic        out_rsp_err,
  input  logic        inp_rsp_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;
  logic                access;
  logic                accept;

  logic                req_we;
  logic [ADDR_W-1:0]   req_idx;
  logic                req_misalign;
  logic [31:0]         req_wdata;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]          req_be;
`endif

  logic [31:0]         mem [0:DEPTH-1];

  // Upper address bits fold into the index wrap; be is meaningless without masking.
  logic                unused_bits;
`ifdef DMEM_BYTE_MASK_EN
  assign unused_bits = ^inp_req_addr[31:ADDR_W+2];
`else
  assign unused_bits = ^{inp_req_addr[31:ADDR_W+2], inp_req_be};
`endif

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (inp_req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (inp_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Ready is registered so it stays low through reset and rises one edge after release.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      out_req_ready <= 1'b0;
    end else begin
      out_req_ready <= (state_next == IDLE);
    end
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      req_we       <= 1'b0;
      req_idx      <= '0;
      req_misalign <= 1'b0;
      req_wdata    <= 32'd0;
`ifdef DMEM_BYTE_MASK_EN
      req_be       <= 4'd0;
`endif
    end else if (accept) begin
      req_we       <= inp_req_we;
      req_idx      <= inp_req_addr[ADDR_W+1:2];
      req_misalign <= (inp_req_addr[1:0] != 2'b00);
      req_wdata    <= inp_req_wdata;
`ifdef DMEM_BYTE_MASK_EN
      req_be       <= inp_req_be;
`endif
    end
  end

  // Storage is deliberately outside reset; access is only possible from WAIT.
  always_ff @(posedge inp_clk) begin
    if (access && req_we && !req_misalign) begin
`ifdef DMEM_BYTE_MASK_EN
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
`else
      mem[req_idx] <= req_wdata;
`endif
    end
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      out_rsp_valid <= 1'b0;
      out_rsp_rdata <= 32'd0;
      out_rsp_err   <= 1'b0;
    end else if (access) begin
      out_rsp_valid <= 1'b1;
      out_rsp_err   <= req_misalign;
      out_rsp_rdata <= (req_misalign || req_we) ? 32'd0 : mem[req_idx];
    end else if ((state == RESP) && inp_rsp_ready) begin
      out_rsp_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
`default_nettype none

module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut (
    .inp_clk       (clk),
    .inp_rst_n     (rst_n),
    .inp_req_valid (req_valid),
    .out_req_ready (req_ready),
    .inp_req_we    (req_we),
    .inp_req_addr  (req_addr),
    .inp_req_wdata (req_wdata),
    .inp_req_be    (req_be),
    .out_rsp_valid (rsp_valid),
    .out_rsp_rdata (rsp_rdata),
    .out_rsp_err   (rsp_err),
    .inp_rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for one edge; returns just after the acceptance edge.
  task automatic accept_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    req_be    = 4'hF;
  endtask

  // Edges counted from the acceptance edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    accept_req(we, addr, wdata, be);
    wait_rsp(lat);
    chk({tag, "_latency"}, lat, 32'd2);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    finish_rsp();
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", {31'd0, req_ready}, 32'd1);

    transact("wr_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    transact("rd_10", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // Misaligned read held in RESP; a stray write presented meanwhile must be ignored.
    accept_req(1'b0, 32'h13, 32'd0, 4'hF);
    wait_rsp(lat);
    chk("mis_latency", lat, 32'd2);
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    held = rsp_rdata;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, held);
      chk("hold_err", {31'd0, rsp_err}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    finish_rsp();
    chk("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
    transact("rd_10_again", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    transact("wr_wrap", 1'b1, 32'h100, 32'h1111_1111, 4'hF, 32'd0, 1'b0);
    transact("rd_0", 1'b0, 32'h0, 32'd0, 4'hF, 32'h1111_1111, 1'b0);
    transact("rd_10_after_wrap", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    transact("wr_20_clear", 1'b1, 32'h20, 32'h0000_0000, 4'hF, 32'd0, 1'b0);
    transact("wr_20_be5", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
`ifdef DMEM_BYTE_MASK_EN
    transact("rd_20_be5", 1'b0, 32'h20, 32'd0, 4'hF, 32'h00BB_00DD, 1'b0);
    transact("wr_20_be0", 1'b1, 32'h20, 32'h1234_5678, 4'b0000, 32'd0, 1'b0);
    transact("rd_20_be0", 1'b0, 32'h20, 32'd0, 4'hF, 32'h00BB_00DD, 1'b0);
`else
    transact("rd_20_be5", 1'b0, 32'h20, 32'd0, 4'hF, 32'hAABB_CCDD, 1'b0);
    transact("wr_20_be0", 1'b1, 32'h20, 32'h1234_5678, 4'b0000, 32'd0, 1'b0);
    transact("rd_20_be0", 1'b0, 32'h20, 32'd0, 4'hF, 32'h1234_5678, 1'b0);
`endif

    // Misaligned write must not touch memory.
    transact("wr_mis", 1'b1, 32'h12, 32'h7777_7777, 4'hF, 32'd0, 1'b1);
    transact("rd_10_after_mis", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // Reset in WAIT of a write discards it.
    accept_req(1'b1, 32'h10, 32'h5555_5555, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("wait_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wait_rst_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("wait_rst_valid_low", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid_low", {31'd0, rsp_valid}, 32'd0);
    end
    transact("rd_10_after_rst", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the word-index width (64 words of 32 bits).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, giving the cycles from request acceptance to response valid.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 inp_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 inp_rst_n  input  1  asynchronous active-low reset.
REQ-006 inp_req_valid  input  1  requester presents a request.
REQ-007 out_req_ready  output  1  responder can accept a request.
REQ-008 inp_req_we  input  1  1 = write, 0 = read.
REQ-009 inp_req_addr  input  32  byte address; word index = addr[ADDR_W+1:2].
REQ-010 inp_req_wdata  input  32  write data.
REQ-011 inp_req_be  input  4  byte lane enables; bit i covers wdata[8i+7:8i].
REQ-012 out_rsp_valid  output  1  response present.
REQ-013 out_rsp_rdata  output  32  read data.
REQ-014 out_rsp_err  output  1  misaligned-access flag.
REQ-015 inp_rsp_ready  input  1  requester accepts the response.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 out_req_ready SHALL be 1 only in IDLE, and 0 in all other states.
REQ-018 A request SHALL be accepted on a rising edge with inp_req_valid=1 in IDLE.
- On acceptance, the block SHALL latch we, addr, wdata and be.
- On acceptance, the block SHALL load the down-counter with LATENCY-1 and enter WAIT.
REQ-019 In WAIT, the counter SHALL decrement once per cycle.
- When the counter is 0, the block SHALL perform the access and enter RESP.
- out_rsp_valid SHALL therefore rise exactly LATENCY cycles after the acceptance edge.
REQ-020 A read SHALL register mem[index] into out_rsp_rdata.
REQ-021 A write SHALL update mem[index] and set out_rsp_rdata to 0.
- Writes also produce a response.
REQ-022 In RESP, out_rsp_valid, out_rsp_rdata and out_rsp_err SHALL hold stable until inp_rsp_ready=1 is sampled.
- On that edge, the block SHALL return to IDLE.
- Without inp_rsp_ready=1, RESP is held indefinitely.
REQ-023 If addr[1:0] is not 0, there SHALL be no memory access, and the response SHALL carry out_rsp_err=1 and out_rsp_rdata=0.
REQ-024 Address bits above ADDR_W+1 SHALL be ignored, so the index wraps modulo 2^ADDR_W.
REQ-025 A read following a write to the same word SHALL return the written value.
REQ-026 Request inputs SHALL be ignored outside IDLE.
- The minimum request spacing SHALL be LATENCY+2 cycles.
REQ-027 With LATENCY=1, the access SHALL occur on the first WAIT cycle.

Reset
REQ-028 Asserting inp_rst_n=0 SHALL immediately force all of the following, independent of inp_clk:
- state to IDLE;
- counter to 0;
- out_rsp_valid=0, out_rsp_rdata=0 and out_rsp_err=0;
- out_req_ready=0.
REQ-029 One cycle after deassertion, out_req_ready SHALL read 1.
REQ-030 Reset during WAIT or RESP SHALL discard the transaction.
- A write whose access cycle has not yet occurred SHALL NOT modify memory.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 With DMEM_BYTE_MASK_EN defined:
- writes SHALL update only lanes whose inp_req_be bit is 1;
- be=4'b0000 SHALL leave memory unchanged but still respond.
REQ-033 Without DMEM_BYTE_MASK_EN:
- inp_req_be SHALL be ignored;
- every write SHALL replace the full word.

Verification
REQ-034 Reset, then write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> the read response has rdata=0xDEADBEEF and err=0, and valid rises 2 cycles after acceptance.
REQ-035 Read addr 0x13 -> err=1 and rdata=0, with memory unchanged.
REQ-036 Hold inp_rsp_ready=0 for 5 cycles in RESP -> valid and rdata stay stable and out_req_ready stays 0, then return to IDLE on the edge where ready=1.
REQ-037 Write 0x11111111 to addr 0x100 (index wraps to 0), then read addr 0x0 -> 0x11111111.
REQ-038 With DMEM_BYTE_MASK_EN, write 0xAABBCCDD with be=4'b0101 over 0x00000000 -> read returns 0x00BB00DD.
REQ-039 Without the macro, the same write reads back 0xAABBCCDD.
REQ-040 Assert reset during WAIT of a write -> the written word is unchanged and out_rsp_valid never rises.
